// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Grant is held until the transfer completes, is abandoned, or is ended by the watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output logic        err_master
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic        last;
  logic [15:0] wd;

  logic granted;
  logic sel1;
  logic cur_valid;
  logic done;
  logic timed_out;

  always_comb begin
    granted   = (state == GRANT0) || (state == GRANT1);
    sel1      = (state == GRANT1);
    cur_valid = sel1 ? m1_valid : m0_valid;
    done      = granted && cur_valid && mem_ready;
    // mem_ready takes priority over an expiring watchdog
    timed_out = granted && cur_valid && !mem_ready && (wd == WD_LIMIT);
  end

  always_comb begin
    mem_valid = granted && cur_valid;
    mem_instr = sel1 ? m1_instr : m0_instr;
    mem_wstrb = sel1 ? m1_wstrb : m0_wstrb;
    mem_wdata = sel1 ? m1_wdata : m0_wdata;
    mem_addr  = sel1 ? m1_addr  : m0_addr;
    m0_ready  = (state == GRANT0) && (done || timed_out);
    m1_ready  = (state == GRANT1) && (done || timed_out);
    m0_rdata  = ((state == GRANT0) && timed_out) ? TIMEOUT_DATA : mem_rdata;
    m1_rdata  = ((state == GRANT1) && timed_out) ? TIMEOUT_DATA : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      wd          <= '0;
      timeout_err <= 1'b0;
      err_master  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          // on a tie, the master other than the last one granted wins
          if (m0_valid && (!m1_valid || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
          end else if (m1_valid) begin
            state <= GRANT1;
            last  <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!cur_valid || done) begin
            state <= GAP;
          end else if (timed_out) begin
            state       <= GAP;
            timeout_err <= 1'b1;
            err_master  <= sel1;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a memory responder with per-transfer
// latency, a transaction-level reference model and a ready monitor.
module tb_mem_arbiter;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] TDATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        timeout_err, err_master;

  mem_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(TDATA)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err), .err_master(err_master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        master;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [7:0]  lat;
  } xfer_t;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
    logic        em;
  } resp_t;

  xfer_t grant_q[$];
  resp_t exp_q0[$];
  resp_t exp_q1[$];

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_mem [16];
  logic [31:0] env_mem   [16];
  logic        model_last, model_err, model_em;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic xfer_t rand_xfer(input logic m, input int lat_force);
    xfer_t x;
    x.master = m;
    x.addr   = 32'($urandom_range(0, 15)) << 2;
    x.wdata  = $urandom;
    x.wstrb  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    x.instr  = 1'($urandom_range(0, 1));
    x.lat    = (lat_force < 0) ? 8'($urandom_range(0, 6)) : 8'(lat_force);
    return x;
  endfunction

  // Reference model: one granted transfer, in the order the arbitration rules dictate.
  task automatic model_xfer(input xfer_t x);
    resp_t r;
    r.chk_data = (x.wstrb == 4'h0);
    if (x.lat > TO) begin
      r.chk_data = 1'b1;
      r.rdata    = TDATA;
      model_err  = 1'b1;
      model_em   = x.master;
    end else begin
      r.rdata = model_mem[x.addr[5:2]];
      if (x.wstrb != 4'h0) model_mem[x.addr[5:2]] = merge(model_mem[x.addr[5:2]], x.wdata, x.wstrb);
    end
    r.err = model_err;
    r.em  = model_em;
    grant_q.push_back(x);
    if (x.master) exp_q1.push_back(r);
    else          exp_q0.push_back(r);
  endtask

  // mode bit0: m0 requests, bit1: m1 requests; both raised in the same IDLE cycle
  task automatic run_round(input int mode, input xfer_t x0, input xfer_t x1);
    logic d0, d1;
    int   cyc;
    if (mode == 1) begin
      model_xfer(x0); model_last = 1'b0;
    end else if (mode == 2) begin
      model_xfer(x1); model_last = 1'b1;
    end else if (model_last) begin
      model_xfer(x0); model_xfer(x1);
    end else begin
      model_xfer(x1); model_xfer(x0);
    end
    @(posedge clk); #1;
    {m0_addr, m0_wdata, m0_wstrb, m0_instr} = {x0.addr, x0.wdata, x0.wstrb, x0.instr};
    {m1_addr, m1_wdata, m1_wstrb, m1_instr} = {x1.addr, x1.wdata, x1.wstrb, x1.instr};
    m0_valid = mode[0];
    m1_valid = mode[1];
    d0 = 1'b0; d1 = 1'b0; cyc = 0;
    while ((m0_valid || m1_valid) && cyc < 100) begin
      @(negedge clk);
      if (m0_valid && m0_ready) d0 = 1'b1;
      if (m1_valid && m1_ready) d1 = 1'b1;
      @(posedge clk); #1;
      if (d0) m0_valid = 1'b0;
      if (d1) m1_valid = 1'b0;
      cyc++;
    end
    if (m0_valid || m1_valid) begin
      check("round_completion", {30'd0, m1_valid, m0_valid}, 32'd0);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
    end
  endtask

  // Memory responder: raises mem_ready in grant cycle lat+1 and checks the forwarded request.
  logic        busy = 1'b0;
  int unsigned cnt;
  xfer_t       cur;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (busy && !mem_valid) busy = 1'b0;
      if (!busy && mem_valid) begin
        busy = 1'b1;
        cnt  = 0;
        if (grant_q.size() == 0) begin
          check("unexpected_grant", {31'd0, mem_valid}, 32'd0);
          cur     = '0;
          cur.lat = 8'hFF;
        end else begin
          cur = grant_q.pop_front();
          check("mem_addr",  mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
          check("mem_instr", {31'd0, mem_instr}, {31'd0, cur.instr});
        end
      end
      if (busy) begin
        if (cnt == 32'(cur.lat)) begin
          mem_ready = 1'b1;
          mem_rdata = env_mem[mem_addr[5:2]];
          if (mem_wstrb != 4'h0)
            env_mem[mem_addr[5:2]] = merge(env_mem[mem_addr[5:2]], mem_wdata, mem_wstrb);
        end
        cnt++;
      end
    end
  end

  // Monitor: pops the expected response on every ready pulse; checks GAP and flags one cycle later.
  logic pend = 1'b0;
  logic pe_err, pe_em;

  task automatic handle_ready(input logic m, input logic [31:0] rdata);
    resp_t r;
    if ((m ? exp_q1.size() : exp_q0.size()) == 0) begin
      check(m ? "m1_spurious_ready" : "m0_spurious_ready", 32'd1, 32'd0);
    end else begin
      r = m ? exp_q1.pop_front() : exp_q0.pop_front();
      if (r.chk_data) check(m ? "m1_rdata" : "m0_rdata", rdata, r.rdata);
      pend   = 1'b1;
      pe_err = r.err;
      pe_em  = r.em;
    end
  endtask

  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      check("gap_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("timeout_err", {31'd0, timeout_err}, {31'd0, pe_err});
      check("err_master", {31'd0, err_master}, {31'd0, pe_em});
    end
    if (m0_ready && m1_ready) check("dual_ready", {30'd0, m1_ready, m0_ready}, 32'd1);
    if (m0_ready) handle_ready(1'b0, m0_rdata);
    if (m1_ready) handle_ready(1'b1, m1_rdata);
  end

  initial begin
    xfer_t a, b;
    reset    = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_wstrb = '0; m0_wdata = '0; m0_addr = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_wstrb = '0; m1_wdata = '0; m1_addr = '0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      env_mem[i]   = model_mem[i];
    end
    model_last = 1'b1; model_err = 1'b0; model_em = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("reset_err_master", {31'd0, err_master}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single read, then timeout, then timeout/ready coincidence
    a = rand_xfer(1'b0, 1); a.addr = 32'h10; a.wstrb = 4'h0;
    b = rand_xfer(1'b1, 1);
    run_round(1, a, b);
    a = rand_xfer(1'b0, 7); a.wstrb = 4'h0;
    run_round(1, a, b);
    a = rand_xfer(1'b0, 4); a.wstrb = 4'h0;
    run_round(1, a, b);
    // byte write by m1 followed by a read of the same word
    b = rand_xfer(1'b1, 2); b.addr = 32'h20; b.wstrb = 4'b0100; b.wdata = 32'h00AB0000;
    run_round(2, a, b);
    b = rand_xfer(1'b1, 1); b.addr = 32'h20; b.wstrb = 4'h0;
    run_round(2, a, b);
    // simultaneous requests alternate
    for (int i = 0; i < 4; i++) run_round(3, rand_xfer(1'b0, 1), rand_xfer(1'b1, 1));

    // reset in GRANT1: no ready to m1, arbitration state and flags return to reset values
    b = rand_xfer(1'b1, 3);
    grant_q.push_back(b);
    @(posedge clk); #1;
    {m1_addr, m1_wdata, m1_wstrb, m1_instr} = {b.addr, b.wdata, b.wstrb, b.instr};
    m1_valid = 1'b1;
    @(negedge clk);
    check("idle_before_grant", {31'd0, mem_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("grant_latency", {31'd0, mem_valid}, 32'd1);
    @(posedge clk); #1;
    reset    = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);
    check("post_reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("post_reset_m1_ready", {31'd0, m1_ready}, 32'd0);
    check("post_reset_timeout_err", {31'd0, timeout_err}, 32'd0);
    model_last = 1'b1; model_err = 1'b0; model_em = 1'b0;
    run_round(3, rand_xfer(1'b0, 1), rand_xfer(1'b1, 1));

    for (int i = 0; i < 40; i++)
      run_round(int'($urandom_range(1, 3)), rand_xfer(1'b0, -1), rand_xfer(1'b1, -1));

    repeat (4) @(posedge clk);
    check("grant_q_drained", grant_q.size(), 32'd0);
    check("exp_q0_drained", exp_q0.size(), 32'd0);
    check("exp_q1_drained", exp_q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
